// File: rtl/wb_conmax_slv_tmo_if.sv
// Wishbone point-to-point bus bundle for the wb_conmax slave-port timeout slice.
// The master modport drives the request (data, address, selects, we, cyc, stb)
// and the slave modport drives the response (read data, ack, err, rty).
interface wb_conmax_slv_tmo_if #(
  parameter int aw = 32,
  parameter int dw = 32,
  parameter int sw = dw / 8
) ();

  logic [dw-1:0] dat_w;
  logic [dw-1:0] dat_r;
  logic [aw-1:0] adr;
  logic [sw-1:0] sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output dat_w, adr, sel, we, cyc, stb,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  dat_w, adr, sel, we, cyc, stb,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_conmax_slv_tmo.sv
// Registered request/response slice with a bus-timeout watchdog, sitting between
// a wb_conmax slave-port arbiter output (s_bus) and the attached slave (wb_bus).
// A hung slave is aborted after to_cyc wait cycles and the master is terminated
// with an error, so the crossbar can never lock up on it.
// Optional macro WB_CONMAX_TMO_RTY_EN: a timeout terminates with rty instead of err.
module wb_conmax_slv_tmo #(
  parameter int            aw     = 32,
  parameter int            dw     = 32,
  parameter int            sw     = dw / 8,
  parameter int            tw     = 8,
  parameter logic [tw-1:0] to_cyc = 8'd255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_conmax_slv_tmo_if.slave     s_bus,
  wb_conmax_slv_tmo_if.master    wb_bus,
  output logic                   to_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen during the last allowed wait cycle (counter starts at 0).
  localparam logic [tw-1:0] TO_LAST = to_cyc - tw'(1);

  state_t        state_q, state_d;
  logic [tw-1:0] cnt_q, cnt_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [dw-1:0] dat_w_q, dat_w_d;
  logic [sw-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [dw-1:0] dat_r_q, dat_r_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;
  logic          to_q, to_d;

  logic          rsp_any;
  logic          tmo_hit;

  assign rsp_any = wb_bus.ack | wb_bus.err | wb_bus.rty;
  assign tmo_hit = (to_cyc != '0) && (cnt_q == TO_LAST);

  // State register for the IDLE/BUSY/RESP sequencer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-register values; abort beats slave response beats timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    dat_r_d = dat_r_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    to_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        if (s_bus.cyc && s_bus.stb) begin
          adr_d   = s_bus.adr;
          dat_w_d = s_bus.dat_w;
          sel_d   = s_bus.sel;
          we_d    = s_bus.we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (!s_bus.cyc) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (rsp_any) begin
          cyc_d   = 1'b0;
          err_d   = wb_bus.err;
          rty_d   = !wb_bus.err && wb_bus.rty;
          ack_d   = !wb_bus.err && !wb_bus.rty && wb_bus.ack;
          dat_r_d = wb_bus.dat_r;
          state_d = RESP;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
`ifdef WB_CONMAX_TMO_RTY_EN
          rty_d   = 1'b1;
`else
          err_d   = 1'b1;
`endif
          to_d    = 1'b1;
          dat_r_d = '0;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + tw'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath, counter and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      dat_r_q <= dat_r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      to_q    <= to_d;
    end
  end

  assign wb_bus.adr   = adr_q;
  assign wb_bus.dat_w = dat_w_q;
  assign wb_bus.sel   = sel_q;
  assign wb_bus.we    = we_q;
  assign wb_bus.cyc   = cyc_q;
  assign wb_bus.stb   = cyc_q;

  assign s_bus.dat_r  = dat_r_q;
  assign s_bus.ack    = ack_q;
  assign s_bus.err    = err_q;
  assign s_bus.rty    = rty_q;

  assign to_o         = to_q;

endmodule

// File: tb/tb_wb_conmax_slv_tmo.sv
// Scoreboard bench for wb_conmax_slv_tmo with to_cyc = 4.
// Each transfer is described by its slave latency, termination mix and optional
// master abort; the expected outcome is derived from those with plain arithmetic
// and pushed into queues that a negedge monitor pops whenever the DUT shows
// a slave-side strobe run or a master-side termination.
module tb_wb_conmax_slv_tmo;

  localparam int TO_CYC = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    logic        we;
    int          lat;
    logic [2:0]  mask;
    int          abt;
    logic        hold;
    int          gap;
  } txn_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          run;
  } req_t;

  typedef struct {
    logic [2:0]  term;
    logic [31:0] data;
    logic        to;
  } rsp_t;

  logic clk;
  logic rst;
  logic to_o;

  int n_checks = 0;
  int n_fail   = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   mon_run = 0;
  req_t mon_cur;

  wb_conmax_slv_tmo_if #(.aw(32), .dw(32), .sw(4)) s_bus ();
  wb_conmax_slv_tmo_if #(.aw(32), .dw(32), .sw(4)) wb_bus ();

  wb_conmax_slv_tmo #(
    .aw(32), .dw(32), .sw(4), .tw(8), .to_cyc(8'd4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s_bus (s_bus),
    .wb_bus(wb_bus),
    .to_o  (to_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    s_bus.cyc    = 1'b0;
    s_bus.stb    = 1'b0;
    s_bus.adr    = '0;
    s_bus.dat_w  = '0;
    s_bus.sel    = '0;
    s_bus.we     = 1'b0;
    wb_bus.ack   = 1'b0;
    wb_bus.err   = 1'b0;
    wb_bus.rty   = 1'b0;
    wb_bus.dat_r = '0;
  endtask

  // Called at posedge+1 of a cycle in which the DUT is expected to be IDLE.
  task automatic applyStimulus(input txn_t t);
    int   d;
    int   span;
    bit   slave_done;
    bit   aborted;
    bit   m;
    req_t rq;
    rsp_t rs;
    slave_done = (t.lat != 0) && (t.lat <= TO_CYC);
    d          = slave_done ? t.lat : TO_CYC;
    aborted    = (t.abt != 0) && (t.abt <= d);
    rq.adr = t.adr; rq.dat = t.dat; rq.sel = t.sel; rq.we = t.we;
    rq.run = aborted ? t.abt : d;
    req_q.push_back(rq);
    if (aborted) begin
      span = (t.lat > t.abt) ? t.lat + 1 : t.abt + 1;
    end else begin
      span = d + 2;
      if (slave_done) begin
        rs.term = t.mask[2] ? 3'b100 : (t.mask[1] ? 3'b010 : 3'b001);
        rs.data = t.rdat;
        rs.to   = 1'b0;
      end else begin
`ifdef WB_CONMAX_TMO_RTY_EN
        rs.term = 3'b010;
`else
        rs.term = 3'b100;
`endif
        rs.data = '0;
        rs.to   = 1'b1;
      end
      rsp_q.push_back(rs);
    end
    for (int c = 0; c < span; c++) begin
      if (aborted) m = (c < t.abt);
      else         m = (c <= d) || ((c == d + 1) && t.hold);
      s_bus.cyc   = m;
      s_bus.stb   = m;
      s_bus.adr   = t.adr;
      s_bus.dat_w = t.dat;
      s_bus.sel   = t.sel;
      s_bus.we    = t.we;
      if (t.lat != 0 && c == t.lat) begin
        {wb_bus.err, wb_bus.rty, wb_bus.ack} = t.mask;
        wb_bus.dat_r = t.rdat;
      end else begin
        {wb_bus.err, wb_bus.rty, wb_bus.ack} = 3'b000;
        wb_bus.dat_r = $urandom;
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g < t.gap; g++) begin
      s_bus.cyc    = 1'b0;
      s_bus.stb    = 1'($urandom_range(0, 1));
      s_bus.adr    = $urandom;
      wb_bus.dat_r = $urandom;
      {wb_bus.err, wb_bus.rty, wb_bus.ack} = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
  endtask

  function automatic txn_t randTxn();
    txn_t t;
    t.adr  = $urandom;
    t.dat  = $urandom;
    t.rdat = $urandom;
    t.sel  = 4'($urandom_range(0, 15));
    t.we   = 1'($urandom_range(0, 1));
    t.lat  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO_CYC + 2));
    t.mask = 3'($urandom_range(1, 7));
    t.abt  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, TO_CYC + 1)) : 0;
    t.hold = 1'($urandom_range(0, 1));
    t.gap  = int'($urandom_range(0, 2));
    return t;
  endfunction

  function automatic txn_t dirTxn(input logic [31:0] adr, input logic we, input int lat,
                                  input logic [2:0] mask, input logic [31:0] rdat, input int abt);
    txn_t t;
    t.adr = adr; t.dat = 32'hA5A5_0000 ^ adr; t.rdat = rdat; t.sel = 4'hF; t.we = we;
    t.lat = lat; t.mask = mask; t.abt = abt; t.hold = 1'b0; t.gap = 0;
    return t;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb_cyc"}, 64'(wb_bus.cyc),   64'd0);
    checkOutput({tag, "_wb_stb"}, 64'(wb_bus.stb),   64'd0);
    checkOutput({tag, "_wb_adr"}, 64'(wb_bus.adr),   64'd0);
    checkOutput({tag, "_wb_dat"}, 64'(wb_bus.dat_w), 64'd0);
    checkOutput({tag, "_wb_sel"}, 64'(wb_bus.sel),   64'd0);
    checkOutput({tag, "_wb_we"},  64'(wb_bus.we),    64'd0);
    checkOutput({tag, "_s_term"}, 64'({s_bus.err, s_bus.rty, s_bus.ack}), 64'd0);
    checkOutput({tag, "_s_dat"},  64'(s_bus.dat_r),  64'd0);
    checkOutput({tag, "_to"},     64'(to_o),         64'd0);
  endtask

  // Monitor: compares strobe runs and terminations against the queued model results.
  always @(negedge clk) begin
    if (rst) begin
      mon_run = 0;
    end else begin
      if (wb_bus.stb) begin
        if (mon_run == 0) begin
          if (req_q.size() == 0) begin
            checkOutput("wb_unexpected_stb", 64'd1, 64'd0);
          end else begin
            mon_cur = req_q.pop_front();
            checkOutput("wb_adr", 64'(wb_bus.adr),   64'(mon_cur.adr));
            checkOutput("wb_dat", 64'(wb_bus.dat_w), 64'(mon_cur.dat));
            checkOutput("wb_sel", 64'(wb_bus.sel),   64'(mon_cur.sel));
            checkOutput("wb_we",  64'(wb_bus.we),    64'(mon_cur.we));
            checkOutput("wb_cyc_on", 64'(wb_bus.cyc), 64'd1);
          end
        end
        mon_run++;
      end else if (mon_run > 0) begin
        checkOutput("wb_stb_len", 64'(mon_run), 64'(mon_cur.run));
        checkOutput("wb_cyc_off", 64'(wb_bus.cyc), 64'd0);
        mon_run = 0;
      end
      if (s_bus.ack || s_bus.err || s_bus.rty) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_term", 64'({s_bus.err, s_bus.rty, s_bus.ack}), 64'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          checkOutput("s_term", 64'({s_bus.err, s_bus.rty, s_bus.ack}), 64'(e.term));
          checkOutput("s_dat",  64'(s_bus.dat_r), 64'(e.data));
          checkOutput("to_o",   64'(to_o),        64'(e.to));
        end
      end else begin
        checkOutput("to_idle", 64'(to_o), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;
    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Read with immediate ack, then back-to-back accept.
    applyStimulus(dirTxn(32'h100, 1'b0, 1, 3'b001, 32'hDEADBEEF, 0));
    // Write acked in the last allowed wait cycle.
    applyStimulus(dirTxn(32'h204, 1'b1, TO_CYC, 3'b001, 32'h1234_5678, 0));
    // Silent slave: timeout.
    applyStimulus(dirTxn(32'h308, 1'b0, 0, 3'b001, 32'h0, 0));
    // ack+err together on the timeout cycle: slave err wins, no to_o.
    applyStimulus(dirTxn(32'h40C, 1'b0, TO_CYC, 3'b101, 32'hCAFE_F00D, 0));
    // rty beats ack.
    applyStimulus(dirTxn(32'h410, 1'b0, 2, 3'b011, 32'h0BAD_0001, 0));
    // Master abort at N+3 with a late ack at N+4.
    applyStimulus(dirTxn(32'h510, 1'b1, 4, 3'b001, 32'h5555_AAAA, 3));
    // Abort in the same cycle as a slave response: response discarded.
    applyStimulus(dirTxn(32'h514, 1'b0, 2, 3'b001, 32'h7777_8888, 2));

    // Reset in the second BUSY cycle.
    s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.adr = 32'h600; s_bus.dat_w = 32'hFEED_BEEF;
    s_bus.sel = 4'hF; s_bus.we = 1'b1;
    {wb_bus.err, wb_bus.rty, wb_bus.ack} = 3'b000;
    begin
      req_t rq;
      rq.adr = 32'h600; rq.dat = 32'hFEED_BEEF; rq.sel = 4'hF; rq.we = 1'b1; rq.run = 0;
      req_q.push_back(rq);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    s_bus.cyc = 1'b0; s_bus.stb = 1'b0;
    #2;
    checkAllZero("rst_busy");
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(dirTxn(32'h700, 1'b0, 1, 3'b001, 32'h0123_4567, 0));

    for (int i = 0; i < 300; i++) begin
      t = randTxn();
      applyStimulus(t);
    end

    idleInputs();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    checkOutput("req_q_drained", 64'(req_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
